// File: rtl/multi_field_setter.sv
// Multi-field value editor driven by debounced SET/INC/DEC buttons or a switch bank.
// Hands the finished set of field values downstream over a valid/ready handshake.
module multi_field_setter #(
  parameter int NUM_FIELDS     = 3,
  parameter int FIELD_W        = 6,
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          btn_set,
  input  logic                          btn_inc,
  input  logic                          btn_dec,
  input  logic [FIELD_W-1:0]            ext_input,
  input  logic                          load,
  input  logic [NUM_FIELDS*FIELD_W-1:0] field_max,
  input  logic                          commit_ready,
  output logic [NUM_FIELDS*FIELD_W-1:0] fields,
  output logic [NUM_FIELDS-1:0]         sel,
  output logic                          editing,
  output logic                          commit_valid,
  output logic                          aborted
);

  // state  | meaning
  // IDLE   | fields hold last committed/restored values
  // EDIT   | user edits field idx; sel is one-hot on idx
  // COMMIT | commit_valid high, waiting for commit_ready

  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EDIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [TO_W-1:0]    to_cnt;

  logic [2:0]         raw;
  logic [2:0]         sync1;
  logic [2:0]         sync2;
  logic [2:0]         clean;
  logic [2:0]         clean_d;
  logic [DEB_W-1:0]   deb_cnt [3];

  logic               set_ev;
  logic               inc_ev;
  logic               dec_ev;

  logic [FIELD_W-1:0] val     [NUM_FIELDS];
  logic [FIELD_W-1:0] shadow  [NUM_FIELDS];
  logic [FIELD_W-1:0] max_arr [NUM_FIELDS];

  logic [FIELD_W-1:0] cur_val;
  logic [FIELD_W-1:0] cur_max;
  logic [FIELD_W-1:0] edit_val;
  logic               edit_en;
  logic               activity;
  logic               timeout_hit;

  assign raw = {btn_dec, btn_inc, btn_set};

  // Clean level flips only after DEB_CYCLES consecutive differing synced samples.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1   <= '0;
      sync2   <= '0;
      clean   <= '0;
      clean_d <= '0;
      for (int b = 0; b < 3; b++) deb_cnt[b] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      clean_d <= clean;
      for (int b = 0; b < 3; b++) begin
        if (sync2[b] == clean[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DEB_LAST) begin
          clean[b]   <= sync2[b];
          deb_cnt[b] <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + DEB_W'(1);
        end
      end
    end
  end

  // SET acts on release so a held button does not skip fields; INC/DEC act on press.
  assign set_ev = clean_d[0] & ~clean[0];
  assign inc_ev = clean[1] & ~clean_d[1];
  assign dec_ev = clean[2] & ~clean_d[2];

  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_pack
    assign fields[i*FIELD_W +: FIELD_W] = val[i];
    assign max_arr[i]                   = field_max[i*FIELD_W +: FIELD_W];
  end

  always_comb begin
    cur_val  = val[idx];
    cur_max  = max_arr[idx];
    edit_val = cur_val;
    if (load) begin
      edit_val = (ext_input > cur_max) ? cur_max : ext_input;
    end else if (inc_ev) begin
      edit_val = (cur_val >= cur_max) ? '0 : cur_val + FIELD_W'(1);
    end else if (dec_ev) begin
      edit_val = ((cur_val == '0) || (cur_val > cur_max)) ? cur_max : cur_val - FIELD_W'(1);
    end
    edit_en     = load | (inc_ev ^ dec_ev);
    activity    = set_ev | inc_ev | dec_ev | load;
    timeout_hit = (TIMEOUT_CYCLES > 0) && !activity && (to_cnt == TO_LAST);
  end

  always_ff @(posedge clk) begin
    aborted <= 1'b0;
    if (!rstn) begin
      state        <= S_IDLE;
      idx          <= '0;
      to_cnt       <= '0;
      sel          <= '0;
      editing      <= 1'b0;
      commit_valid <= 1'b0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        val[i]    <= '0;
        shadow[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (set_ev) begin
            state   <= S_EDIT;
            idx     <= '0;
            to_cnt  <= '0;
            sel     <= NUM_FIELDS'(1);
            editing <= 1'b1;
            for (int i = 0; i < NUM_FIELDS; i++) shadow[i] <= val[i];
          end
        end
        S_EDIT: begin
          if (edit_en) val[idx] <= edit_val;
          if (activity) begin
            to_cnt <= '0;
          end else if (TIMEOUT_CYCLES > 0) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
          if (set_ev) begin
            if (idx == LAST_IDX) begin
              state        <= S_COMMIT;
              sel          <= '0;
              editing      <= 1'b0;
              commit_valid <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
              sel <= sel << 1;
            end
          end else if (timeout_hit) begin
            // User walked away: drop the partial edit.
            for (int i = 0; i < NUM_FIELDS; i++) val[i] <= shadow[i];
            state   <= S_IDLE;
            sel     <= '0;
            editing <= 1'b0;
            aborted <= 1'b1;
          end
        end
        S_COMMIT: begin
          if (commit_ready) begin
            state        <= S_IDLE;
            commit_valid <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          sel          <= '0;
          editing      <= 1'b0;
          commit_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_field_setter.sv
// Directed bench for multi_field_setter: debounce, edit arithmetic, commit handshake,
// timeout restore, max lowering and reset during COMMIT.
module tb_multi_field_setter;

  localparam int NF = 3;
  localparam int FW = 6;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              btn_set = 1'b0;
  logic              btn_inc = 1'b0;
  logic              btn_dec = 1'b0;
  logic [FW-1:0]     ext_input = '0;
  logic              load = 1'b0;
  logic [NF*FW-1:0]  field_max = '0;
  logic              commit_ready = 1'b0;
  logic [NF*FW-1:0]  fields;
  logic [NF-1:0]     sel;
  logic              editing;
  logic              commit_valid;
  logic              aborted;

  int n_checks = 0;
  int n_errors = 0;
  int k;

  multi_field_setter #(
    .NUM_FIELDS(NF),
    .FIELD_W(FW),
    .DEB_CYCLES(4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .btn_set(btn_set),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .ext_input(ext_input),
    .load(load),
    .field_max(field_max),
    .commit_ready(commit_ready),
    .fields(fields),
    .sel(sel),
    .editing(editing),
    .commit_valid(commit_valid),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0=SET, 1=INC, 2=DEC, 3=INC+DEC together
  task automatic press(input int which);
    case (which)
      0: btn_set = 1'b1;
      1: btn_inc = 1'b1;
      2: btn_dec = 1'b1;
      default: begin btn_inc = 1'b1; btn_dec = 1'b1; end
    endcase
    tick(12);
    btn_set = 1'b0;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    tick(12);
  endtask

  task automatic load_val(input logic [FW-1:0] v);
    ext_input = v;
    load = 1'b1;
    tick(2);
    load = 1'b0;
    tick(1);
  endtask

  function automatic logic [63:0] pack3(input int f0, input int f1, input int f2);
    logic [NF*FW-1:0] p;
    p = {FW'(f2), FW'(f1), FW'(f0)};
    return 64'(p);
  endfunction

  initial begin
    field_max = {6'd59, 6'd59, 6'd23};
    tick(3);
    check("rst_fields", fields, 0);
    check("rst_sel", sel, 0);
    check("rst_editing", editing, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_aborted", aborted, 0);
    rstn = 1'b1;
    tick(2);

    // Bounce then clean hold and release
    btn_set = 1'b1; tick(1);
    btn_set = 1'b0; tick(1);
    btn_set = 1'b1; tick(10);
    check("no_edit_during_hold", editing, 0);
    btn_set = 1'b0;
    k = 0;
    while (!editing && k < 30) begin
      tick(1);
      k++;
    end
    check("set_latency", k, 7);
    check("sel_entry", sel, 3'b001);
    tick(10);
    check("single_set_ev", sel, 3'b001);

    // Field 0, max 23
    press(2);
    check("dec_wrap_0_to_max", fields[FW-1:0], 23);
    press(1);
    check("inc_wrap_max_to_0", fields[FW-1:0], 0);
    press(2);
    check("dec_again", fields[FW-1:0], 23);
    press(3);
    check("inc_dec_same_cycle", fields[FW-1:0], 23);

    // Field 1, max 59
    press(0);
    check("sel_idx1", sel, 3'b010);
    load_val(6'd63);
    check("load_clamped", fields[2*FW-1:FW], 59);

    // Field 2: load has priority over INC
    press(0);
    check("sel_idx2", sel, 3'b100);
    ext_input = 6'd42;
    load = 1'b1;
    press(1);
    load = 1'b0;
    tick(1);
    check("load_beats_inc", fields[3*FW-1:2*FW], 42);

    press(0);
    check("commit_valid_up", commit_valid, 1);
    check("commit_editing_low", editing, 0);
    check("commit_sel_zero", sel, 0);
    check("commit_fields", fields, pack3(23, 59, 42));

    commit_ready = 1'b0;
    press(1);
    tick(5);
    check("commit_hold_fields", fields, pack3(23, 59, 42));
    check("commit_hold_valid", commit_valid, 1);
    commit_ready = 1'b1;
    tick(1);
    commit_ready = 1'b0;
    check("commit_done_valid", commit_valid, 0);
    check("commit_done_editing", editing, 0);

    // Build {1,2,3} and commit
    press(0); load_val(6'd1);
    press(0); load_val(6'd2);
    press(0); load_val(6'd3);
    press(0);
    commit_ready = 1'b1;
    tick(1);
    commit_ready = 1'b0;
    check("committed_123", fields, pack3(1, 2, 3));

    // Timeout restore
    press(0);
    check("to_editing", editing, 1);
    press(1);
    check("to_inc", fields[FW-1:0], 2);
    k = 0;
    while (!aborted && k < 200) begin
      tick(1);
      k++;
    end
    check("to_latency", k, 83);
    check("to_restored", fields, pack3(1, 2, 3));
    check("to_editing_low", editing, 0);
    check("to_sel_zero", sel, 0);
    tick(1);
    check("to_pulse_one_cycle", aborted, 0);

    // Lowered max does not touch the field until edited
    field_max = {6'd2, 6'd59, 6'd23};
    tick(2);
    check("max_lowered_hold", fields[3*FW-1:2*FW], 3);
    press(0);
    press(0);
    press(0);
    check("sel_idx2_again", sel, 3'b100);
    press(2);
    check("dec_above_max", fields[3*FW-1:2*FW], 2);

    // Reset during COMMIT
    press(0);
    check("commit2_valid", commit_valid, 1);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    check("rst_commit_fields", fields, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_editing", editing, 0);
    press(0);
    check("post_rst_sel", sel, 3'b001);
    check("post_rst_editing", editing, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
